// File: rtl/wb_byte_master_pkg.sv
// Shared opcodes, response codes and FSM encoding for the byte-stream Wishbone master.
package wb_byte_master_pkg;

    localparam logic [7:0] CMD_WRITE = 8'h01;
    localparam logic [7:0] CMD_READ  = 8'h02;
    localparam logic [7:0] RSP_ACK   = 8'h06;
    localparam logic [7:0] RSP_NAK   = 8'h15;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_WDATA = 3'd2,
        ST_BUS   = 3'd3,
        ST_RESP  = 3'd4
    } state_t;

    function automatic logic is_cmd(input logic [7:0] b);
        return (b == CMD_WRITE) || (b == CMD_READ);
    endfunction

endpackage

// File: rtl/wb_byte_master_txq.sv
// Response byte queue: up to 4 bytes sent MSB first, one tx_wr strobe per byte,
// with the transmitter's busy flag ignored while it is still catching up on a strobe.
module wb_byte_master_txq
    import wb_byte_master_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        i_load,
    input  logic [31:0] i_load_data,
    input  logic [2:0]  i_load_cnt,
    input  logic        i_tx_busy,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_wr,
    output logic        o_idle
);

    logic [31:0] r_shift;
    logic [2:0]  r_cnt;
    logic [1:0]  r_hold;
    logic [7:0]  r_tx_data;
    logic        r_tx_wr;
    logic        w_send;

    // r_hold covers the strobe cycle and the one after it, before busy is trusted
    assign w_send = (r_cnt != 3'd0) && (r_hold == 2'd0) && !i_tx_busy;

    // Byte shifter, remaining count and strobe generation
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_shift   <= 32'h0000_0000;
            r_cnt     <= 3'd0;
            r_hold    <= 2'd0;
            r_tx_data <= 8'h00;
            r_tx_wr   <= 1'b0;
        end else if (i_load) begin
            r_shift <= i_load_data;
            r_cnt   <= i_load_cnt;
            r_hold  <= 2'd0;
            r_tx_wr <= 1'b0;
        end else if (w_send) begin
            r_tx_data <= r_shift[31:24];
            r_shift   <= {r_shift[23:0], 8'h00};
            r_cnt     <= r_cnt - 3'd1;
            r_hold    <= 2'd2;
            r_tx_wr   <= 1'b1;
        end else begin
            r_tx_wr <= 1'b0;
            if (r_hold != 2'd0) begin
                r_hold <= r_hold - 2'd1;
            end
        end
    end

    assign o_tx_data = r_tx_data;
    assign o_tx_wr   = r_tx_wr;
    assign o_idle    = (r_cnt == 3'd0);

endmodule

// File: rtl/wb_byte_master.sv
// Byte-stream driven Wishbone classic master: parses WRITE/READ commands,
// runs one single-word bus cycle with timeout, and answers through the tx queue.
module wb_byte_master
    import wb_byte_master_pkg::*;
#(
    parameter int unsigned timeout_cycles = 1023
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_wr,
    input  logic        tx_busy,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    output logic        busy,
    output logic        overrun
);

    localparam logic [15:0] TMO_LAST = 16'(timeout_cycles - 1);

    state_t      r_state, w_state_next;
    logic        r_is_write;
    logic [1:0]  r_byte;
    logic [31:0] r_adr, r_dat;
    logic        r_cyc, r_we;
    logic [3:0]  r_sel;
    logic [15:0] r_tmo;
    logic        r_busy, r_ovr;
    logic        w_last_byte, w_open, w_term, w_load, w_txq_idle;
    logic [31:0] w_load_data;
    logic [2:0]  w_load_cnt;

    assign w_last_byte = rx_valid && (r_byte == 2'd3);

    // Next-state decode, bus termination and response selection
    always_comb begin
        w_state_next = r_state;
        w_open       = 1'b0;
        w_term       = 1'b0;
        w_load       = 1'b0;
        w_load_data  = 32'h0000_0000;
        w_load_cnt   = 3'd0;
        case (r_state)
            ST_IDLE: begin
                if (rx_valid && is_cmd(rx_data)) begin
                    w_state_next = ST_ADDR;
                end else if (rx_valid) begin
                    w_state_next = ST_RESP;
                    w_load       = 1'b1;
                    w_load_data  = {RSP_NAK, 24'h00_0000};
                    w_load_cnt   = 3'd1;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_ADDR: begin
                if (w_last_byte && r_is_write) begin
                    w_state_next = ST_WDATA;
                end else if (w_last_byte) begin
                    w_state_next = ST_BUS;
                    w_open       = 1'b1;
                end else begin
                    w_state_next = ST_ADDR;
                end
            end
            ST_WDATA: begin
                if (w_last_byte) begin
                    w_state_next = ST_BUS;
                    w_open       = 1'b1;
                end else begin
                    w_state_next = ST_WDATA;
                end
            end
            ST_BUS: begin
                // err outranks ack, and a timeout is reported the same way as err
                if (r_cyc && (wb_err_i || (r_tmo == TMO_LAST))) begin
                    w_state_next = ST_RESP;
                    w_term       = 1'b1;
                    w_load       = 1'b1;
                    w_load_data  = {RSP_NAK, 24'h00_0000};
                    w_load_cnt   = 3'd1;
                end else if (r_cyc && wb_ack_i) begin
                    w_state_next = ST_RESP;
                    w_term       = 1'b1;
                    w_load       = 1'b1;
                    if (r_is_write) begin
                        w_load_data = {RSP_ACK, 24'h00_0000};
                        w_load_cnt  = 3'd1;
                    end else begin
                        w_load_data = wb_dat_i;
                        w_load_cnt  = 3'd4;
                    end
                end else begin
                    w_state_next = ST_BUS;
                end
            end
            ST_RESP: begin
                if (w_txq_idle) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_state_next = ST_RESP;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Command shifters, bus signals, timeout counter and status flags
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_is_write <= 1'b0;
            r_byte     <= 2'd0;
            r_adr      <= 32'h0000_0000;
            r_dat      <= 32'h0000_0000;
            r_cyc      <= 1'b0;
            r_we       <= 1'b0;
            r_sel      <= 4'h0;
            r_tmo      <= 16'h0000;
            r_busy     <= 1'b0;
            r_ovr      <= 1'b0;
        end else begin
            r_busy <= (w_state_next != ST_IDLE);
            r_ovr  <= rx_valid && ((r_state == ST_BUS) || (r_state == ST_RESP));
            case (r_state)
                ST_IDLE: begin
                    if (rx_valid && is_cmd(rx_data)) begin
                        r_is_write <= (rx_data == CMD_WRITE);
                        r_byte     <= 2'd0;
                    end
                end
                ST_ADDR: begin
                    if (rx_valid) begin
                        r_adr  <= {r_adr[23:0], rx_data};
                        r_byte <= r_byte + 2'd1;
                    end
                end
                ST_WDATA: begin
                    if (rx_valid) begin
                        r_dat  <= {r_dat[23:0], rx_data};
                        r_byte <= r_byte + 2'd1;
                    end
                end
                ST_BUS: begin
                    if (w_term) begin
                        r_cyc <= 1'b0;
                        r_we  <= 1'b0;
                        r_sel <= 4'h0;
                    end else begin
                        r_tmo <= r_tmo + 16'd1;
                    end
                end
                default: begin
                end
            endcase
            if (w_open) begin
                r_cyc <= 1'b1;
                r_we  <= r_is_write;
                r_sel <= 4'hF;
                r_tmo <= 16'h0000;
            end
        end
    end

    wb_byte_master_txq u_txq (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_load      (w_load),
        .i_load_data (w_load_data),
        .i_load_cnt  (w_load_cnt),
        .i_tx_busy   (tx_busy),
        .o_tx_data   (tx_data),
        .o_tx_wr     (tx_wr),
        .o_idle      (w_txq_idle)
    );

    assign wb_adr_o = r_adr & 32'hFFFF_FFFC;
    assign wb_dat_o = r_dat;
    assign wb_sel_o = r_sel;
    assign wb_we_o  = r_we;
    assign wb_cyc_o = r_cyc;
    assign wb_stb_o = r_cyc;
    assign busy     = r_busy;
    assign overrun  = r_ovr;

endmodule

// File: tb/tb_wb_byte_master.sv
// Directed bench for wb_byte_master with a scripted Wishbone slave and a
// transmitter model that holds busy for several cycles after each strobe.
module tb_wb_byte_master;

    logic        clk;
    logic        reset_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_wr;
    logic        tx_busy;
    logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o, wb_cyc_o, wb_stb_o, wb_ack_i, wb_err_i;
    logic        busy, overrun;

    int n_chk  = 0;
    int n_fail = 0;

    // slave script and observations
    int          ack_at   = 1;
    logic        err_mode = 1'b0;
    logic [31:0] rdata    = 32'h0;
    int          ncyc     = 0;
    int          cyc_hi   = 0;
    int          ccnt     = 0;
    logic        prev_cyc = 1'b0;
    logic [31:0] cap_adr, cap_dat;
    logic        cap_we, cap_stb;
    logic [3:0]  cap_sel;

    // transmitter observations
    logic [7:0] tx_log[$];
    int         bcnt    = 0;
    int         viol    = 0;
    int         ovr_cnt = 0;

    wb_byte_master #(.timeout_cycles(8)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_wr    (tx_wr),
        .tx_busy  (tx_busy),
        .wb_adr_o (wb_adr_o),
        .wb_dat_o (wb_dat_o),
        .wb_dat_i (wb_dat_i),
        .wb_sel_o (wb_sel_o),
        .wb_we_o  (wb_we_o),
        .wb_cyc_o (wb_cyc_o),
        .wb_stb_o (wb_stb_o),
        .wb_ack_i (wb_ack_i),
        .wb_err_i (wb_err_i),
        .busy     (busy),
        .overrun  (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
        n_chk++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp_v);
        end
    endtask

    function automatic logic [31:0] pop_tx();
        logic [7:0] b;
        if (tx_log.size() == 0) return 32'hFFFF_FFFF;
        b = tx_log.pop_front();
        return {24'h0, b};
    endfunction

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send5(input logic [7:0] op, input logic [31:0] adr);
        send_byte(op);
        for (int i = 3; i >= 0; i--) send_byte(adr[i*8 +: 8]);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        check_val(tag, 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic clear_obs();
        tx_log.delete();
        cyc_hi  = 0;
        viol    = 0;
        ovr_cnt = 0;
    endtask

    // scripted slave: acks (optionally with err) in cycle ack_at of the bus cycle
    initial begin
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
        wb_dat_i = 32'h0;
        forever begin
            @(negedge clk);
            if (wb_cyc_o) begin
                if (!prev_cyc) begin
                    ncyc++;
                    ccnt    = 0;
                    cap_adr = wb_adr_o;
                    cap_dat = wb_dat_o;
                    cap_we  = wb_we_o;
                    cap_sel = wb_sel_o;
                    cap_stb = wb_stb_o;
                end
                ccnt++;
                cyc_hi++;
                if (ack_at != 0 && ccnt == ack_at) begin
                    wb_ack_i = 1'b1;
                    wb_err_i = err_mode;
                    wb_dat_i = rdata;
                end else begin
                    wb_ack_i = 1'b0;
                    wb_err_i = 1'b0;
                end
            end else begin
                wb_ack_i = 1'b0;
                wb_err_i = 1'b0;
            end
            prev_cyc = wb_cyc_o;
        end
    end

    // transmitter model: busy for 4 cycles after each strobe, logs bytes
    initial begin
        tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (overrun) ovr_cnt++;
            if (tx_wr) begin
                if (bcnt > 0) viol++;
                tx_log.push_back(tx_data);
                bcnt    = 4;
                tx_busy = 1'b1;
            end else if (bcnt > 0) begin
                bcnt--;
                if (bcnt == 0) tx_busy = 1'b0;
            end
        end
    end

    initial begin
        int c0;
        reset_n  = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(negedge clk);
        check_val("rst_cyc",  32'(wb_cyc_o), 32'd0);
        check_val("rst_sel",  32'(wb_sel_o), 32'd0);
        check_val("rst_adr",  wb_adr_o,      32'd0);
        check_val("rst_txwr", 32'(tx_wr),    32'd0);
        check_val("rst_busy", 32'(busy),     32'd0);
        reset_n = 1'b1;

        // WRITE, slave acks in second bus cycle
        clear_obs();
        ack_at = 2; err_mode = 1'b0;
        c0 = ncyc;
        send5(8'h01, 32'h0000_7008);
        send_word(32'hDEAD_BEEF);
        check_val("wr_latency", 32'(wb_cyc_o), 32'd1);
        wait_idle("wr_idle");
        check_val("wr_ncyc",  32'(ncyc - c0), 32'd1);
        check_val("wr_cychi", 32'(cyc_hi),    32'd2);
        check_val("wr_adr",   cap_adr,        32'h0000_7008);
        check_val("wr_dat",   cap_dat,        32'hDEAD_BEEF);
        check_val("wr_we",    32'(cap_we),    32'd1);
        check_val("wr_stb",   32'(cap_stb),   32'd1);
        check_val("wr_sel",   32'(cap_sel),   32'hF);
        check_val("wr_ntx",   32'(tx_log.size()), 32'd1);
        check_val("wr_rsp",   pop_tx(),       32'h06);
        check_val("wr_selidle", 32'(wb_sel_o), 32'd0);

        // READ, 4 response bytes paced by tx_busy
        clear_obs();
        ack_at = 1; rdata = 32'h1234_5678;
        send5(8'h02, 32'h4000_0010);
        wait_idle("rd_idle");
        check_val("rd_adr",  cap_adr,     32'h4000_0010);
        check_val("rd_we",   32'(cap_we), 32'd0);
        check_val("rd_ntx",  32'(tx_log.size()), 32'd4);
        check_val("rd_b0",   pop_tx(), 32'h12);
        check_val("rd_b1",   pop_tx(), 32'h34);
        check_val("rd_b2",   pop_tx(), 32'h56);
        check_val("rd_b3",   pop_tx(), 32'h78);
        check_val("rd_busyviol", 32'(viol), 32'd0);

        // READ timeout: no ack ever
        clear_obs();
        ack_at = 0;
        send5(8'h02, 32'h0000_0100);
        wait_idle("to_idle");
        check_val("to_cychi", 32'(cyc_hi), 32'd8);
        check_val("to_ntx",   32'(tx_log.size()), 32'd1);
        check_val("to_rsp",   pop_tx(), 32'h15);

        // err together with ack
        clear_obs();
        ack_at = 1; err_mode = 1'b1; rdata = 32'hCAFE_F00D;
        send5(8'h02, 32'h0000_0200);
        wait_idle("err_idle");
        err_mode = 1'b0;
        check_val("err_ntx", 32'(tx_log.size()), 32'd1);
        check_val("err_rsp", pop_tx(), 32'h15);

        // bad opcode in IDLE
        clear_obs();
        c0 = ncyc;
        send_byte(8'h7F);
        wait_idle("bad_idle");
        check_val("bad_ncyc", 32'(ncyc - c0), 32'd0);
        check_val("bad_ntx",  32'(tx_log.size()), 32'd1);
        check_val("bad_rsp",  pop_tx(), 32'h15);

        // overrun during BUS, then a clean command
        clear_obs();
        ack_at = 6; rdata = 32'hA5C3_0F96;
        send5(8'h02, 32'h0000_0020);
        send_byte(8'h99);
        wait_idle("ovr_idle");
        check_val("ovr_pulses", 32'(ovr_cnt), 32'd1);
        check_val("ovr_ntx", 32'(tx_log.size()), 32'd4);
        check_val("ovr_b0",  pop_tx(), 32'hA5);
        check_val("ovr_b3",  {24'h0, tx_log.size() == 3 ? tx_log[2] : 8'hEE}, 32'h96);
        clear_obs();
        ack_at = 1;
        send5(8'h01, 32'h0000_0044);
        send_word(32'h1122_3344);
        wait_idle("ovr2_idle");
        check_val("ovr2_adr", cap_adr, 32'h0000_0044);
        check_val("ovr2_dat", cap_dat, 32'h1122_3344);
        check_val("ovr2_rsp", pop_tx(), 32'h06);

        // async reset while the cycle is open
        clear_obs();
        ack_at = 0;
        send5(8'h02, 32'h0000_0008);
        repeat (2) @(negedge clk);
        check_val("mid_cyc_pre", 32'(wb_cyc_o), 32'd1);
        reset_n = 1'b0;
        #1;
        check_val("mid_cyc",  32'(wb_cyc_o), 32'd0);
        check_val("mid_stb",  32'(wb_stb_o), 32'd0);
        check_val("mid_txwr", 32'(tx_wr),    32'd0);
        check_val("mid_busy", 32'(busy),     32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (6) @(negedge clk);
        clear_obs();
        ack_at = 1;
        send5(8'h01, 32'h0000_0C00);
        send_word(32'h0BAD_F00D);
        wait_idle("post_idle");
        check_val("post_adr", cap_adr,     32'h0000_0C00);
        check_val("post_dat", cap_dat,     32'h0BAD_F00D);
        check_val("post_we",  32'(cap_we), 32'd1);
        check_val("post_rsp", pop_tx(),    32'h06);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
